// File: rtl/pe_cluster_feeder_if.sv
// pe_cluster_feeder_if
//   Bundles the stream and write-port signals of the PE cluster feeder.
//   Signal names keep the feeder's point of view (i_* into the feeder, o_* out of it).
//
//   upstream stream : i_s_data, i_s_valid  -> feeder,  o_s_ready      <- feeder
//   weight port     : o_weight_data, o_weight_valid, o_wr_w_row_ptr, o_wr_w_col_ptr <- feeder
//   ifmap port      : o_ifmap_data, o_ifmap_valid, o_reset_ifmap                     <- feeder
//
//   modport master : the feeder itself
//   modport slave  : the environment (upstream buffer and PE cluster side)
interface pe_cluster_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PTR_W      = 5
);
  logic [DATA_WIDTH-1:0] i_s_data;
  logic                  i_s_valid;
  logic                  o_s_ready;

  logic [DATA_WIDTH-1:0] o_weight_data;
  logic                  o_weight_valid;
  logic [PTR_W-1:0]      o_wr_w_row_ptr;
  logic [PTR_W-1:0]      o_wr_w_col_ptr;

  logic [DATA_WIDTH-1:0] o_ifmap_data;
  logic                  o_ifmap_valid;
  logic                  o_reset_ifmap;

  modport master (
    input  i_s_data, i_s_valid,
    output o_s_ready,
    output o_weight_data, o_weight_valid, o_wr_w_row_ptr, o_wr_w_col_ptr,
    output o_ifmap_data, o_ifmap_valid, o_reset_ifmap
  );

  modport slave (
    output i_s_data, i_s_valid,
    input  o_s_ready,
    input  o_weight_data, o_weight_valid, o_wr_w_row_ptr, o_wr_w_col_ptr,
    input  o_ifmap_data, o_ifmap_valid, o_reset_ifmap
  );
endinterface

// File: rtl/pe_cluster_feeder.sv
// pe_cluster_feeder
//   Per tile: optionally loads a fw x fw weight block row-major from the upstream
//   stream, pulses an ifmap reset, streams ifmap_len ifmap words, then pulses done.
//
//   clk, reset          : clock, synchronous active-high reset
//   i_start             : tile start (accepted only in IDLE)
//   i_filter_width      : filter side, latched at accepted start
//   i_ifmap_len         : ifmap words in the tile, latched at accepted start
//   i_load_weight       : 0 skips the weight phase, latched at accepted start
//   i_stall             : cluster backpressure, only gates o_s_ready
//   bus                 : stream in, weight write port, ifmap write port
//   o_busy / o_done     : not idle / one-cycle end-of-tile pulse
//   o_starve_cycles     : present only with PE_FEEDER_STARVE_CNT_EN defined;
//                         saturating count of ready-but-no-valid cycles
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for i_start
// LOAD_W    | accepting fw*fw weight words, row-major
// RST_IF    | single cycle, issues the ifmap reset pulse
// STREAM_IF | accepting ifmap_len ifmap words
// DONE      | single cycle, issues o_done
module pe_cluster_feeder #(
  parameter int DATA_WIDTH       = 16,
  parameter int MAX_FILTER_WIDTH = 11,
  parameter int MAX_IFMAP_LEN    = 256,
  localparam int LOG_MFW = $clog2(MAX_FILTER_WIDTH),
  localparam int LOG_MIL = $clog2(MAX_IFMAP_LEN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [LOG_MFW:0]         i_filter_width,
  input  logic [LOG_MIL:0]         i_ifmap_len,
  input  logic                     i_load_weight,
  input  logic                     i_stall,
  pe_cluster_feeder_if.master      bus,
  output logic                     o_busy,
`ifdef PE_FEEDER_STARVE_CNT_EN
  output logic [31:0]              o_starve_cycles,
`endif
  output logic                     o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RST_IF,
    S_STREAM_IF,
    S_DONE
  } state_t;

  localparam logic [LOG_MFW:0] FW_ONE  = 1;
  localparam logic [LOG_MIL:0] LEN_ONE = 1;

  state_t                state_q, state_d;
  logic [LOG_MFW:0]      fw_q, fw_d;
  logic [LOG_MIL:0]      len_q, len_d;
  logic [LOG_MFW:0]      row_q, row_d;
  logic [LOG_MFW:0]      col_q, col_d;
  logic [LOG_MIL:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic [LOG_MFW:0]      wrow_q, wrow_d;
  logic [LOG_MFW:0]      wcol_q, wcol_d;
  logic [DATA_WIDTH-1:0] idata_q, idata_d;
  logic                  ivalid_q, ivalid_d;
  logic                  rstif_q, rstif_d;
  logic                  done_q, done_d;

  logic                  ready;
  logic                  beat;
  logic [LOG_MFW:0]      fw_last;
  logic [LOG_MIL:0]      len_last;

  assign ready    = ((state_q == S_LOAD_W) || (state_q == S_STREAM_IF)) && !i_stall;
  assign beat     = bus.i_s_valid && ready;
  assign fw_last  = fw_q - FW_ONE;
  assign len_last = len_q - LEN_ONE;

  always_comb begin
    state_d  = state_q;
    fw_d     = fw_q;
    len_d    = len_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    wrow_d   = wrow_q;
    wcol_d   = wcol_q;
    idata_d  = idata_q;
    wvalid_d = 1'b0;
    ivalid_d = 1'b0;
    rstif_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          fw_d  = i_filter_width;
          len_d = i_ifmap_len;
          row_d = '0;
          col_d = '0;
          cnt_d = '0;
          // A zero-width filter has no weights to load even if asked to.
          if (i_load_weight && (i_filter_width != '0)) state_d = S_LOAD_W;
          else                                         state_d = S_RST_IF;
        end
      end

      S_LOAD_W: begin
        if (beat) begin
          wdata_d  = bus.i_s_data;
          wvalid_d = 1'b1;
          wrow_d   = row_q;
          wcol_d   = col_q;
          if (col_q == fw_last) begin
            col_d = '0;
            if (row_q == fw_last) state_d = S_RST_IF;
            else                  row_d   = row_q + FW_ONE;
          end else begin
            col_d = col_q + FW_ONE;
          end
        end
      end

      S_RST_IF: begin
        rstif_d = 1'b1;
        if (len_q == '0) state_d = S_DONE;
        else             state_d = S_STREAM_IF;
      end

      S_STREAM_IF: begin
        if (beat) begin
          idata_d  = bus.i_s_data;
          ivalid_d = 1'b1;
          if (cnt_q == len_last) state_d = S_DONE;
          else                   cnt_d   = cnt_q + LEN_ONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fw_q     <= '0;
      len_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      wrow_q   <= '0;
      wcol_q   <= '0;
      idata_q  <= '0;
      ivalid_q <= 1'b0;
      rstif_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fw_q     <= fw_d;
      len_q    <= len_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      wrow_q   <= wrow_d;
      wcol_q   <= wcol_d;
      idata_q  <= idata_d;
      ivalid_q <= ivalid_d;
      rstif_q  <= rstif_d;
      done_q   <= done_d;
    end
  end

`ifdef PE_FEEDER_STARVE_CNT_EN
  logic [31:0] starve_q, starve_d;

  // Start is only accepted in IDLE, where ready is 0, so clear and count never collide.
  always_comb begin
    starve_d = starve_q;
    if ((state_q == S_IDLE) && i_start)
      starve_d = '0;
    else if (ready && !bus.i_s_valid && (starve_q != '1))
      starve_d = starve_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign o_starve_cycles = starve_q;
`endif

  assign bus.o_s_ready      = ready;
  assign bus.o_weight_data  = wdata_q;
  assign bus.o_weight_valid = wvalid_q;
  assign bus.o_wr_w_row_ptr = wrow_q;
  assign bus.o_wr_w_col_ptr = wcol_q;
  assign bus.o_ifmap_data   = idata_q;
  assign bus.o_ifmap_valid  = ivalid_q;
  assign bus.o_reset_ifmap  = rstif_q;
  assign o_busy             = (state_q != S_IDLE);
  assign o_done             = done_q;

endmodule
